// File: rtl/msg_sequencer.sv
// Message sequencer: plays up to eight 3-bit character codes into the code register,
// one per prescaler tick, with free-run, loop and single-step modes.
module msg_sequencer #(
  parameter int TICK_DIV = 25000000,
  parameter int CNT_W    = 25
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       WrEn,
  input  logic [2:0] WrAddr,
  input  logic [2:0] WrData,
  input  logic [2:0] Len,
  input  logic       Run,
  input  logic       Loop,
  input  logic       Step,
  output logic [2:0] D,
  output logic       Load,
  output logic [2:0] Index,
  output logic       Busy,
  output logic       Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [2:0]       mem_r [8];
  logic             step_q_r;
  logic [2:0]       d_r, index_r;
  logic             load_r, busy_r, done_r;

  logic             tick_s, at_end_s, step_edge_s, restart_s, adv_s;
  logic [2:0]       nxt_idx_s;

  assign tick_s      = (cnt_r == TICK_LAST);
  assign at_end_s    = (index_r >= Len);
  assign nxt_idx_s   = at_end_s ? 3'd0 : index_r + 3'd1;
  assign step_edge_s = Step & ~step_q_r;

  // State register, prescaler and step edge history
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      step_q_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      step_q_r <= Step;
    end
  end

  // Next state, prescaler next value and datapath commands
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = '0;
    restart_s   = 1'b0;
    adv_s       = 1'b0;
    case (state_r)
      IDLE: begin
        // Run has priority over a simultaneous Step edge
        if (Run) begin
          state_nxt_s = RUN;
          restart_s   = 1'b1;
        end else if (step_edge_s) begin
          adv_s = 1'b1;
        end else begin
          adv_s = 1'b0;
        end
      end
      RUN: begin
        if (!Run) begin
          state_nxt_s = IDLE;
        end else if (tick_s) begin
          if (at_end_s && !Loop) begin
            state_nxt_s = DONE;
          end else begin
            adv_s = 1'b1;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      DONE: begin
        if (!Run) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Message memory, registered character output and status flags
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < 8; i++) mem_r[i] <= 3'd0;
      d_r     <= 3'd0;
      index_r <= 3'd0;
      load_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      if (WrEn) begin
        mem_r[WrAddr] <= WrData;
      end
      // Reads see the pre-write memory contents, so a same-address write is not forwarded
      if (restart_s) begin
        index_r <= 3'd0;
        d_r     <= mem_r[0];
        load_r  <= 1'b1;
      end else if (adv_s) begin
        index_r <= nxt_idx_s;
        d_r     <= mem_r[nxt_idx_s];
        load_r  <= 1'b1;
      end else begin
        load_r  <= 1'b0;
      end
      busy_r <= (state_nxt_s == RUN);
      done_r <= (state_nxt_s == DONE);
    end
  end

  assign D     = d_r;
  assign Load  = load_r;
  assign Index = index_r;
  assign Busy  = busy_r;
  assign Done  = done_r;

endmodule

// File: tb/tb_msg_sequencer.sv
// Directed self-checking bench for msg_sequencer with a 4-cycle prescaler.
module tb_msg_sequencer;

  logic       Clock, Resetn, WrEn, Run, Loop, Step;
  logic [2:0] WrAddr, WrData, Len;
  logic [2:0] D, Index;
  logic       Load, Busy, Done;

  int checks = 0;
  int errors = 0;
  logic [2:0] msg [4] = '{3'd3, 3'd5, 3'd1, 3'd7};

  msg_sequencer #(.TICK_DIV(4), .CNT_W(3)) dut (
    .Clock(Clock), .Resetn(Resetn), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .Len(Len), .Run(Run), .Loop(Loop), .Step(Step),
    .D(D), .Load(Load), .Index(Index), .Busy(Busy), .Done(Done)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic write_mem(input logic [2:0] a, input logic [2:0] v);
    WrEn = 1'b1; WrAddr = a; WrData = v;
    tick();
    WrEn = 1'b0;
  endtask

  task automatic test_reset();
    Resetn = 1'b1; WrEn = 1'b0; WrAddr = 3'd0; WrData = 3'd0;
    Len = 3'd0; Run = 1'b0; Loop = 1'b0; Step = 1'b0;
    #1 Resetn = 1'b0;
    tick(); tick();
    checks++;
    if ({D, Load, Index, Busy, Done} !== 9'd0) begin
      errors++; $display("FAIL reset_outputs got %b exp 0", {D, Load, Index, Busy, Done});
    end
    Resetn = 1'b1;
    for (int i = 0; i < 4; i++) write_mem(3'(i), msg[i]);
  endtask

  task automatic test_run_once();
    Len = 3'd3; Loop = 1'b0; Run = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      logic exp_load;
      tick();
      exp_load = (c % 4 == 1) && (c <= 13);
      checks++;
      if (Load !== exp_load) begin
        errors++; $display("FAIL once_load c=%0d got %b exp %b", c, Load, exp_load);
      end
      if (exp_load) begin
        checks++;
        if (D !== msg[(c-1)/4] || Index !== 3'((c-1)/4)) begin
          errors++; $display("FAIL once_data c=%0d got D=%0d I=%0d exp D=%0d I=%0d", c, D, Index, msg[(c-1)/4], (c-1)/4);
        end
      end
      checks++;
      if (c < 17 && (Busy !== 1'b1 || Done !== 1'b0)) begin
        errors++; $display("FAIL once_busy c=%0d got busy=%b done=%b exp 1/0", c, Busy, Done);
      end else if (c >= 17 && (Busy !== 1'b0 || Done !== 1'b1 || D !== 3'd7 || Index !== 3'd3)) begin
        errors++; $display("FAIL once_done c=%0d got busy=%b done=%b D=%0d I=%0d exp 0/1 D=7 I=3", c, Busy, Done, D, Index);
      end
    end
    Run = 1'b0;
    tick();
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0 || Load !== 1'b0 || D !== 3'd7) begin
      errors++; $display("FAIL once_exit got done=%b busy=%b load=%b D=%0d exp 0/0/0 D=7", Done, Busy, Load, D);
    end
  endtask

  task automatic test_loop();
    Loop = 1'b1; Run = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      logic exp_load;
      int k;
      tick();
      exp_load = (c % 4 == 1);
      k = ((c - 1) / 4) % 4;
      checks++;
      if (Load !== exp_load || Done !== 1'b0 || Busy !== 1'b1) begin
        errors++; $display("FAIL loop_ctl c=%0d got load=%b done=%b busy=%b exp %b/0/1", c, Load, Done, Busy, exp_load);
      end
      if (exp_load) begin
        checks++;
        if (D !== msg[k] || Index !== 3'(k)) begin
          errors++; $display("FAIL loop_data c=%0d got D=%0d I=%0d exp D=%0d I=%0d", c, D, Index, msg[k], k);
        end
      end
    end
    Run = 1'b0; Loop = 1'b0;
    tick();
  endtask

  task automatic test_step();
    logic [2:0] exp_idx [3] = '{3'd1, 3'd2, 3'd0};
    int loads;
    Run = 1'b1; Step = 1'b1;
    tick();
    checks++;
    if (Load !== 1'b1 || Index !== 3'd0 || D !== 3'd3 || Busy !== 1'b1) begin
      errors++; $display("FAIL step_runwins got load=%b I=%0d D=%0d busy=%b exp 1/0/3/1", Load, Index, D, Busy);
    end
    Run = 1'b0; Step = 1'b0; Len = 3'd2;
    tick();
    for (int p = 0; p < 3; p++) begin
      Step = 1'b1;
      tick();
      checks++;
      if (Load !== 1'b1 || Index !== exp_idx[p] || D !== msg[exp_idx[p]] || Busy !== 1'b0) begin
        errors++; $display("FAIL step_pulse p=%0d got load=%b I=%0d D=%0d exp 1 I=%0d D=%0d", p, Load, Index, D, exp_idx[p], msg[exp_idx[p]]);
      end
      Step = 1'b0;
      tick();
      checks++;
      if (Load !== 1'b0) begin
        errors++; $display("FAIL step_single p=%0d got load=%b exp 0", p, Load);
      end
      tick();
    end
    Step = 1'b1;
    loads = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (Load === 1'b1) loads++;
    end
    checks++;
    if (loads != 1 || Index !== 3'd1 || D !== 3'd5) begin
      errors++; $display("FAIL step_held got loads=%0d I=%0d D=%0d exp 1 I=1 D=5", loads, Index, D);
    end
    Step = 1'b0;
    tick();
  endtask

  task automatic test_len_change();
    for (int lp = 0; lp < 2; lp++) begin
      Len = 3'd7; Loop = 1'(lp); Run = 1'b1;
      for (int c = 1; c <= 13; c++) tick();
      checks++;
      if (Load !== 1'b1 || Index !== 3'd3 || D !== 3'd7) begin
        errors++; $display("FAIL len_pre lp=%0d got load=%b I=%0d D=%0d exp 1 I=3 D=7", lp, Load, Index, D);
      end
      Len = 3'd1;
      for (int c = 14; c <= 16; c++) tick();
      tick();
      checks++;
      if (lp == 0 && (Done !== 1'b1 || Load !== 1'b0 || Index !== 3'd3 || D !== 3'd7)) begin
        errors++; $display("FAIL len_done got done=%b load=%b I=%0d D=%0d exp 1/0 I=3 D=7", Done, Load, Index, D);
      end else if (lp == 1 && (Load !== 1'b1 || Index !== 3'd0 || D !== 3'd3 || Busy !== 1'b1)) begin
        errors++; $display("FAIL len_wrap got load=%b I=%0d D=%0d busy=%b exp 1 I=0 D=3 busy=1", Load, Index, D, Busy);
      end
      Run = 1'b0;
      tick();
    end
    Len = 3'd3; Loop = 1'b0;
  endtask

  task automatic test_drop_run();
    Run = 1'b1;
    for (int c = 1; c <= 6; c++) tick();
    Run = 1'b0;
    tick();
    checks++;
    if (Busy !== 1'b0 || Load !== 1'b0 || D !== 3'd5 || Index !== 3'd1) begin
      errors++; $display("FAIL drop_hold got busy=%b load=%b D=%0d I=%0d exp 0/0 D=5 I=1", Busy, Load, D, Index);
    end
    tick();
    write_mem(3'd1, 3'd2);
    checks++;
    if (D !== 3'd5 || Load !== 1'b0) begin
      errors++; $display("FAIL drop_write got D=%0d load=%b exp D=5 load=0", D, Load);
    end
    Run = 1'b1;
    tick();
    checks++;
    if (Load !== 1'b1 || D !== 3'd3 || Index !== 3'd0) begin
      errors++; $display("FAIL drop_restart got load=%b D=%0d I=%0d exp 1 D=3 I=0", Load, D, Index);
    end
    for (int c = 2; c <= 5; c++) tick();
    checks++;
    if (Load !== 1'b1 || D !== 3'd2 || Index !== 3'd1) begin
      errors++; $display("FAIL drop_newval got load=%b D=%0d I=%0d exp 1 D=2 I=1", Load, D, Index);
    end
  endtask

  task automatic test_async_reset();
    tick();
    #3 Resetn = 1'b0;
    #1;
    checks++;
    if ({D, Load, Index, Busy, Done} !== 9'd0) begin
      errors++; $display("FAIL areset_outputs got %b exp 0", {D, Load, Index, Busy, Done});
    end
    Run = 1'b0;
    tick();
    Resetn = 1'b1;
    Run = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      logic exp_load;
      tick();
      exp_load = (c % 4 == 1);
      checks++;
      if (Load !== exp_load || D !== 3'd0 || Index !== 3'((c - 1) / 4) || Busy !== 1'b1) begin
        errors++; $display("FAIL areset_replay c=%0d got load=%b D=%0d I=%0d busy=%b exp %b D=0 I=%0d busy=1", c, Load, D, Index, Busy, exp_load, (c - 1) / 4);
      end
    end
    Run = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_run_once();
    test_loop();
    test_step();
    test_len_change();
    test_drop_run();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
